// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor front end: fetch FSM states,
// the halt encoding and instruction field positions used by fetch and decode.
package proc_pkg;

  localparam int unsigned INSTR_W = 9;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  localparam int unsigned TYPE_MSB = 8;
  localparam int unsigned TYPE_LSB = 7;
  localparam int unsigned OP_MSB   = 6;
  localparam int unsigned OP_LSB   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  function automatic logic [1:0] instr_type(input logic [INSTR_W-1:0] instr);
    return instr[TYPE_MSB:TYPE_LSB];
  endfunction

  function automatic logic [2:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register and next-fetch-address mux
// (start / redirect / stall / increment).
module fetch_pc #(
  parameter int unsigned   PW         = 10,
  parameter logic [PW-1:0] START_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_run,
  input  logic          i_load,
  input  logic          i_stall,
  input  logic          i_redirect_en,
  input  logic [PW-1:0] i_redirect_target,
  output logic [PW-1:0] o_addr_c,
  output logic [PW-1:0] o_pc
);

  logic [PW-1:0] r_pc;
  logic [PW-1:0] w_addr;

  // Outside RUN the ROM is pointed at the start address so a start fetches it.
  always_comb begin
    w_addr = START_ADDR;
    if (i_run) begin
      if (i_redirect_en) begin
        w_addr = i_redirect_target;
      end else if (i_stall) begin
        w_addr = r_pc;
      end else begin
        w_addr = r_pc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
    end else if (i_run || i_load) begin
      r_pc <= w_addr;
    end
  end

  assign o_addr_c = w_addr;
  assign o_pc     = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction ROM,
// tracks valid/done and counts retired instructions.
module fetch_unit #(
  parameter int unsigned   PW         = 10,
  parameter int unsigned   IW         = 9,
  parameter int unsigned   CW         = 16,
  parameter logic [PW-1:0] START_ADDR = '0,
  parameter logic [IW-1:0] HALT_INSTR = proc_pkg::HALT_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          redirect_en,
  input  logic [PW-1:0] redirect_target,
  output logic [PW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [PW-1:0] pc_out,
  output logic          done,
  output logic [CW-1:0] instr_count
);

  import proc_pkg::*;

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic          r_valid;
  logic          w_valid_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  logic w_run;
  logic w_load;
  logic w_retire;
  logic w_halt;
  logic w_redirect;

  assign w_run    = (r_state == RUN);
  assign w_load   = !w_run && start;
  assign w_retire = w_run && r_valid && !stall;
  assign w_halt   = w_retire && (imem_data == HALT_INSTR);
  // A retiring halt overrides any redirect resolved in the same cycle.
  assign w_redirect = redirect_en && !w_halt;

  fetch_pc #(
    .PW         (PW),
    .START_ADDR (START_ADDR)
  ) u_fetch_pc (
    .clk               (clk),
    .reset             (reset),
    .i_run             (w_run),
    .i_load            (w_load),
    .i_stall           (stall),
    .i_redirect_en     (w_redirect),
    .i_redirect_target (redirect_target),
    .o_addr_c          (imem_addr),
    .o_pc              (pc_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    w_count_nxt = r_count;
    case (r_state)
      RUN: begin
        if (w_retire && (r_count != {CW{1'b1}})) begin
          w_count_nxt = r_count + CW'(1);
        end
        if (w_halt) begin
          w_state_nxt = HALTED;
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        if (start) begin
          w_state_nxt = RUN;
          w_valid_nxt = 1'b1;
          w_done_nxt  = 1'b0;
          w_count_nxt = '0;
        end
      end
    endcase
  end

  assign instr       = imem_data;
  assign instr_valid = r_valid;
  assign done        = r_done;
  assign instr_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a cycle model pushes expected outputs,
// which are popped and compared after each clock edge.
module tb_fetch_unit;

  localparam int unsigned M_IDLE   = 0;
  localparam int unsigned M_RUN    = 1;
  localparam int unsigned M_HALTED = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stall;
  logic       redirect_en;
  logic [9:0] redirect_target;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic [8:0] instr;
  logic       instr_valid;
  logic [9:0] pc_out;
  logic       done;
  logic [15:0] instr_count;

  logic       s4_start;
  logic       s4_zero;
  logic [3:0] s4_target;
  logic [3:0] imem_addr4;
  logic [8:0] imem_data4;
  logic [8:0] instr4;
  logic       valid4;
  logic [3:0] pc4;
  logic       done4;
  logic [2:0] count4;

  logic [8:0] rom  [1024];
  logic [8:0] rom4 [16];

  typedef struct packed {
    logic [9:0]  pc;
    logic        valid;
    logic        done;
    logic [15:0] count;
  } exp_t;

  exp_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned m_state;
  logic [9:0]  m_pc;
  logic        m_valid;
  logic        m_done;
  logic [15:0] m_count;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stall           (stall),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .pc_out          (pc_out),
    .done            (done),
    .instr_count     (instr_count)
  );

  fetch_unit #(
    .PW         (4),
    .IW         (9),
    .CW         (3),
    .START_ADDR (4'd14),
    .HALT_INSTR (9'h1FF)
  ) dut4 (
    .clk             (clk),
    .reset           (reset),
    .start           (s4_start),
    .stall           (s4_zero),
    .redirect_en     (s4_zero),
    .redirect_target (s4_target),
    .imem_addr       (imem_addr4),
    .imem_data       (imem_data4),
    .instr           (instr4),
    .instr_valid     (valid4),
    .pc_out          (pc4),
    .done            (done4),
    .instr_count     (count4)
  );

  always_ff @(posedge clk) begin
    imem_data  <= rom[imem_addr];
    imem_data4 <= rom4[imem_addr4];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_pc    = '0;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_count = '0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs, predict, compare.
  task automatic step(input logic st, input logic sl, input logic rd, input logic [9:0] tg);
    exp_t       e;
    logic [9:0] ea;
    bit         ret;
    bit         hlt;
    start = st; stall = sl; redirect_en = rd; redirect_target = tg;
    @(negedge clk);
    ret = (m_state == M_RUN) && m_valid && !sl;
    hlt = ret && (rom[m_pc] == 9'h1FF);
    if (m_state != M_RUN)  ea = 10'd0;
    else if (rd && !hlt)   ea = tg;
    else if (sl)           ea = m_pc;
    else                   ea = m_pc + 10'd1;
    if (!(rd && hlt)) chk("imem_addr", 32'(imem_addr), 32'(ea));
    if (m_valid) chk("instr", 32'(instr), 32'(rom[m_pc]));
    if (m_state != M_RUN) begin
      m_valid = 1'b0;
      if (st) begin
        m_state = M_RUN; m_pc = 10'd0; m_valid = 1'b1; m_done = 1'b0; m_count = '0;
      end
    end else begin
      m_pc = ea;
      if (ret && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (hlt) begin
        m_state = M_HALTED; m_valid = 1'b0; m_done = 1'b1;
      end
    end
    e.pc = m_pc; e.valid = m_valid; e.done = m_done; e.count = m_count;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("instr_valid", 32'(instr_valid), 32'(e.valid));
    chk("done", 32'(done), 32'(e.done));
    chk("instr_count", 32'(instr_count), 32'(e.count));
    if (e.valid) chk("pc_out", 32'(pc_out), 32'(e.pc));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'(i & 'hFF);
    for (int i = 0; i < 16; i++) rom4[i] = 9'(i + 1);
    reset = 1'b1; start = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_target = '0;
    s4_start = 1'b0; s4_zero = 1'b0; s4_target = '0;
    model_reset();
    #2;
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Sequential fetch, stall, redirects, ignored start, wrap at 0x3FF
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 10'h3F0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 10'h3F0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 10'h3FD);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    chk("async_pc", 32'(pc_out), 32'd0);
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_count", 32'(instr_count), 32'd0);
    chk("async_addr", 32'(imem_addr), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // Halt at address 5, then restart
    rom[5] = 9'h1FF;
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_count", 32'(instr_count), 32'd6);
    step(1, 0, 0, 0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_pc", 32'(pc_out), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 10'h3F0);
    chk("halt_over_redirect", 32'(done), 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Narrow PC wraps 14,15,0,1 and small counter saturates
    s4_start = 1'b1;
    @(posedge clk);
    #1;
    s4_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("pw4_pc", 32'(pc4), 32'((14 + k) % 16));
      chk("pw4_valid", 32'(valid4), 32'd1);
      chk("pw4_count", 32'(count4), 32'((k < 7) ? k : 7));
      chk("pw4_instr", 32'(instr4), 32'((((14 + k) % 16) + 1)));
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
